// File: rtl/prog_mem_loader.sv
// Framed byte-stream loader for program_memory: assembles 64-bit words,
// writes them, then optionally reads them back against the frame checksum.
module prog_mem_loader #(
  parameter int MEM_WORDS = 8192,
  parameter bit VERIFY    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        prog_en_h,
  output logic        w_en,
  output logic [15:0] adr_p_mem,
  output logic [63:0] data_in,
  input  logic [63:0] data_out
);

  typedef enum logic [2:0] {
    HDR, DATA, WR, CSUM, DRAIN, VRD, VCHK
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [15:0] start_q, start_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  bi_q, bi_d;
  logic [63:0] asm_q, asm_d;
  logic [15:0] k_q, k_d;
  logic [15:0] vc_q, vc_d;
  logic [19:0] drain_q, drain_d;
  logic [7:0]  rx_x_q, rx_x_d;
  logic [7:0]  rx_csum_q, rx_csum_d;
  logic [7:0]  rd_x_q, rd_x_d;
  logic [15:0] adr_q, adr_d;
  logic [63:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic        rdy_c;
  logic        pen_c;
  logic        wen_c;
  logic [15:0] cnt_full;
  logic [16:0] end_sum;
  logic        over;

  function automatic logic [7:0] xor8(input logic [63:0] w);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r = r ^ w[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    start_d   = start_q;
    count_d   = count_q;
    bi_d      = bi_q;
    asm_d     = asm_q;
    k_d       = k_q;
    vc_d      = vc_q;
    drain_d   = drain_q;
    rx_x_d    = rx_x_q;
    rx_csum_d = rx_csum_q;
    rd_x_d    = rd_x_q;
    adr_d     = adr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = err_q;
    busy_d    = busy_q;
    rdy_c     = 1'b0;
    pen_c     = 1'b0;
    wen_c     = 1'b0;
    cnt_full  = {s_data, count_q[7:0]};
    end_sum   = {1'b0, start_q} + {1'b0, cnt_full};
    over      = end_sum > 17'(MEM_WORDS);

    // busy spans the done cycle, then drops unless a new frame starts
    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      HDR: begin
        rdy_c = 1'b1;
        if (s_valid) begin
          hcnt_d = hcnt_q + 2'd1;
          unique case (hcnt_q)
            2'd0: begin
              start_d[7:0] = s_data;
              busy_d       = 1'b1;
              err_d        = 1'b0;
              rx_x_d       = 8'h00;
            end
            2'd1: start_d[15:8] = s_data;
            2'd2: count_d[7:0]  = s_data;
            2'd3: begin
              count_d[15:8] = s_data;
              k_d           = 16'd0;
              bi_d          = 3'd0;
              if (over) begin
                drain_d = {1'b0, cnt_full, 3'b000} + 20'd1;
                state_d = DRAIN;
              end else if (cnt_full == 16'd0) begin
                state_d = CSUM;
              end else begin
                state_d = DATA;
              end
            end
          endcase
        end
      end
      DATA: begin
        rdy_c = 1'b1;
        if (s_valid) begin
          asm_d  = {s_data, asm_q[63:8]};
          rx_x_d = rx_x_q ^ s_data;
          bi_d   = bi_q + 3'd1;
          if (bi_q == 3'd7) state_d = WR;
        end
      end
      WR: begin
        pen_c  = 1'b1;
        wen_c  = 1'b1;
        adr_d  = start_q + k_q;
        data_d = asm_q;
        k_d    = k_q + 16'd1;
        if (k_q + 16'd1 == count_q) state_d = CSUM;
        else state_d = DATA;
      end
      CSUM: begin
        rdy_c = 1'b1;
        if (s_valid) begin
          rx_csum_d = s_data;
          if (s_data != rx_x_q) err_d = 1'b1;
          if (VERIFY && count_q != 16'd0) begin
            vc_d    = 16'd0;
            rd_x_d  = 8'h00;
            state_d = VRD;
          end else begin
            done_d  = 1'b1;
            state_d = HDR;
          end
        end
      end
      DRAIN: begin
        rdy_c = 1'b1;
        if (s_valid) begin
          drain_d = drain_q - 20'd1;
          if (drain_q == 20'd1) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = HDR;
          end
        end
      end
      VRD: begin
        // address j issued in cycle j, its data folded in cycle j+1
        pen_c = 1'b1;
        if (vc_q != count_q) adr_d = start_q + vc_q;
        if (vc_q != 16'd0) rd_x_d = rd_x_q ^ xor8(data_out);
        vc_d = vc_q + 16'd1;
        if (vc_q == count_q) state_d = VCHK;
      end
      VCHK: begin
        if (rd_x_q != rx_csum_q) err_d = 1'b1;
        done_d  = 1'b1;
        state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HDR;
      hcnt_q    <= 2'd0;
      start_q   <= 16'd0;
      count_q   <= 16'd0;
      bi_q      <= 3'd0;
      asm_q     <= 64'd0;
      k_q       <= 16'd0;
      vc_q      <= 16'd0;
      drain_q   <= 20'd0;
      rx_x_q    <= 8'h00;
      rx_csum_q <= 8'h00;
      rd_x_q    <= 8'h00;
      adr_q     <= 16'd0;
      data_q    <= 64'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      start_q   <= start_d;
      count_q   <= count_d;
      bi_q      <= bi_d;
      asm_q     <= asm_d;
      k_q       <= k_d;
      vc_q      <= vc_d;
      drain_q   <= drain_d;
      rx_x_q    <= rx_x_d;
      rx_csum_q <= rx_csum_d;
      rd_x_q    <= rd_x_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready   = rdy_c & ~rst;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign prog_en_h = pen_c;
  assign w_en      = wen_c;
  assign adr_p_mem = adr_d;
  assign data_in   = data_d;

endmodule
